// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the instruction fetch sequencer:
// data/address width, flag bit positions and FSM state encodings.
package fetch_sequencer_pkg;

  localparam int DATA_W   = 8;
  localparam int FLAG_W   = 2;
  localparam int FLAG_BWD = 0;
  localparam int FLAG_OVF = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Next-PC calculation: 9-bit increment, then an optional 9-bit unsigned branch add.
// Both carries are exposed so the sequencer can detect address-space overflow.
module pc_next_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] pc,
  input  logic              branch,
  input  logic [DATA_W-1:0] offset,
  output logic [DATA_W-1:0] next,
  output logic              c1,
  output logic              c2
);

  logic [DATA_W:0] inc;
  logic [DATA_W:0] tgt;

  assign inc  = {1'b0, pc} + (DATA_W+1)'(1);
  // The branch target is built from the truncated increment, so c2 is independent of c1.
  assign tgt  = {1'b0, inc[DATA_W-1:0]} + {1'b0, offset};
  assign c1   = inc[DATA_W];
  assign c2   = tgt[DATA_W];
  assign next = branch ? tgt[DATA_W-1:0] : inc[DATA_W-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests one byte at pc, holds it for the decoder,
// then advances pc sequentially or by branch, faulting permanently on pc overflow.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic              memReq,
  output logic [DATA_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instr,
  input  logic              instrAccept,
  input  logic              branchReq,
  input  logic [DATA_W-1:0] branchOffset,
  output logic [DATA_W-1:0] pcAddress,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  state_t              state_q;
  logic [DATA_W-1:0]   pc_q;
  logic [DATA_W-1:0]   instr_q;
  logic [FLAG_W-1:0]   flags_q;

  logic [DATA_W-1:0]   pc_d;
  logic                c1;
  logic                c2;
  logic                fault;
  logic                backward;

  pc_next_calc u_pc_next_calc (
    .pc     (pc_q),
    .branch (branchReq),
    .offset (branchOffset),
    .next   (pc_d),
    .c1     (c1),
    .c2     (c2)
  );

  assign fault    = c1 | (branchReq & c2);
  assign backward = branchReq & (pc_d <= pc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      flags_q[FLAG_BWD] <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (memAck) begin
            instr_q <= memData;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instrAccept) begin
            if (fault) begin
              flags_q[FLAG_OVF] <= 1'b1;
              state_q           <= S_FAULT;
            end else begin
              pc_q              <= pc_d;
              flags_q[FLAG_BWD] <= backward;
              state_q           <= halt ? S_IDLE : S_FETCH;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come only from registers, so reset drops them without waiting for a clock.
  assign memReq     = (state_q == S_FETCH);
  assign memAddr    = pc_q;
  assign instrValid = (state_q == S_HOLD);
  assign instr      = instr_q;
  assign pcAddress  = pc_q;
  assign flags      = flags_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_HOLD);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a cycle-level reference
// model that computes pc progression and overflow with plain integer arithmetic.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       halt;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memAck;
  logic [7:0] memData;
  logic       instrValid;
  logic [7:0] instr;
  logic       instrAccept;
  logic       branchReq;
  logic [7:0] branchOffset;
  logic [7:0] pcAddress;
  logic [1:0] flags;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 fetching, 2 holding, 3 faulted.
  int         m_state;
  int         m_pc;
  logic [7:0] m_instr;
  logic       m_ovf;
  logic       m_bwd;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memAck       (memAck),
    .memData      (memData),
    .instrValid   (instrValid),
    .instr        (instr),
    .instrAccept  (instrAccept),
    .branchReq    (branchReq),
    .branchOffset (branchOffset),
    .pcAddress    (pcAddress),
    .flags        (flags),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".memReq"},     8'(memReq),     8'(m_state == 1));
    check({tag, ".memAddr"},    memAddr,        8'(m_pc));
    check({tag, ".instrValid"}, 8'(instrValid), 8'(m_state == 2));
    check({tag, ".instr"},      instr,          m_instr);
    check({tag, ".pc"},         pcAddress,      8'(m_pc));
    check({tag, ".flags"},      8'(flags),      8'({m_ovf, m_bwd}));
    check({tag, ".busy"},       8'(busy),       8'(m_state == 1 || m_state == 2));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_instr = 8'h00;
    m_ovf   = 1'b0;
    m_bwd   = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit h, input bit ack, input logic [7:0] d,
                            input bit acc, input bit br, input logic [7:0] off);
    int t;
    m_bwd = 1'b0;
    case (m_state)
      0: if (st) m_state = 1;
      1: if (ack) begin
           m_instr = d;
           m_state = 2;
         end
      2: if (acc) begin
           t = m_pc + 1 + (br ? int'(off) : 0);
           if (m_pc == 255 || t > 255) begin
             m_ovf   = 1'b1;
             m_state = 3;
           end else begin
             m_bwd   = br && (t <= m_pc);
             $display("txn pc=%02h instr=%02h br=%0d off=%02h -> pc=%02h halt=%0d",
                      m_pc[7:0], m_instr, br, off, t[7:0], h);
             m_pc    = t;
             m_state = h ? 0 : 1;
           end
         end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit st, input bit h, input bit ack, input logic [7:0] d,
                     input bit acc, input bit br, input logic [7:0] off, input string tag);
    start = st; halt = h; memAck = ack; memData = d;
    instrAccept = acc; branchReq = br; branchOffset = off;
    @(posedge clk);
    model_step(st, h, ack, d, acc, br, off);
    #1;
    check_all(tag);
  endtask

  task automatic fa(input logic [7:0] d, input bit br, input logic [7:0] off, input bit h,
                    input string tag);
    cyc(0, 0, 1, d, 0, 0, 8'h00, {tag, ".ack"});
    cyc(0, h, 0, 8'h00, 1, br, off, {tag, ".acc"});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    start = 0; halt = 0; memAck = 0; memData = 0;
    instrAccept = 0; branchReq = 0; branchOffset = 0;
    #2;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    do_reset("rst0");

    // First fetch: ack two cycles after request, data A5.
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, "r036.start");
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, "r036.wait1");
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, "r036.wait2");
    cyc(0, 0, 1, 8'hA5, 0, 0, 8'h00, "r036.ack");
    check("r036.instrA5", instr, 8'hA5);
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h00, "r036.acc");
    check("r036.pc01", pcAddress, 8'h01);
    check("r036.req01", 8'({memReq, memAddr[6:0]}), 8'h81);

    // Branches: 02+0E=10, 11+05=16, 17+09=20, then 21+F0 overflows.
    fa(8'h11, 1, 8'h0E, 0, "r037.b10");
    check("r037.pc10", pcAddress, 8'h10);
    fa(8'h22, 1, 8'h05, 0, "r037.b16");
    check("r037.pc16", pcAddress, 8'h16);
    check("r037.nobwd", 8'(flags[0]), 8'h00);
    fa(8'h33, 1, 8'h09, 0, "r037.b20");
    fa(8'h44, 1, 8'hF0, 0, "r037.bF0");
    check("r037.fault", 8'(flags), 8'h02);
    check("r037.pc20", pcAddress, 8'h20);

    // Sequential overflow at FF; fault is sticky even with start held.
    do_reset("rst1");
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, "r038.start");
    fa(8'h55, 1, 8'hFE, 0, "r038.bFF");
    check("r038.pcFF", pcAddress, 8'hFF);
    fa(8'h66, 0, 8'h00, 0, "r038.inc");
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h77, 1, 0, 8'h00, "r038.stuck");
    check("r038.flags", 8'(flags), 8'h02);
    check("r038.req", 8'(memReq), 8'h00);
    check("r038.pc", pcAddress, 8'hFF);

    // Halt on accept returns to idle with pc retained; start resumes there.
    do_reset("rst2");
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, "r039.start");
    fa(8'h88, 1, 8'h2F, 0, "r039.b30");
    fa(8'h99, 0, 8'h00, 1, "r039.halt");
    check("r039.pc31", pcAddress, 8'h31);
    check("r039.idle", 8'(busy), 8'h00);
    cyc(0, 0, 1, 8'h12, 1, 0, 8'h00, "r039.ignored");
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, "r039.resume");
    check("r039.addr31", memAddr, 8'h31);

    // Reset mid-fetch drops memReq without a clock; late ack is ignored.
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, "r040.wait");
    #3;
    reset  = 1'b0;
    memAck = 1'b1;
    #1;
    model_reset();
    check("r040.reqdrop", 8'(memReq), 8'h00);
    check_all("r040.async");
    @(posedge clk);
    #1;
    check_all("r040.held");
    reset = 1'b1;
    cyc(0, 0, 1, 8'hEE, 0, 0, 8'h00, "r040.lateack");
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, "r040.start");
    check("r040.addr00", memAddr, 8'h00);

    // Randomized traffic, recovering from faults with reset.
    do_reset("rst3");
    for (int i = 0; i < 400; i++) begin
      if (m_state == 3 && ($urandom % 4) == 0) begin
        do_reset("rnd.rst");
      end else begin
        cyc($urandom % 2, ($urandom % 4) == 0, ($urandom % 3) == 0, 8'($urandom),
            $urandom % 2, $urandom % 2,
            (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom % 8), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
